cp0_exc_seq: RTL and testbench

CP0_EXC_SEQ -- requirements
Module: cp0_exc_seq

---
 rtl/cp0_exc_seq.sv | 102 ++++++++++
 tb/tb_cp0_exc_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_seq.sv
// cp0_exc_seq: CP0 exception entry / ERET sequencer.
// Ports: clk, rst (async, active-high); exc_req/exc_code/exc_pc and eret_req start a sequence from IDLE;
// cp0_r/cp0_raddr read CP0 through cp0_rdata; cp0_w/cp0_waddr/cp0_wdata write CP0;
// busy marks a sequence in flight; pc_load/pc_target redirect the PC; done pulses at completion.
module cp0_exc_seq #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0040_0004,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_req,
  input  logic [31:0] cp0_rdata,
  output logic        cp0_r,
  output logic [4:0]  cp0_raddr,
  output logic        cp0_w,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        busy,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, RD_STAT, WR_STAT, WR_CAUSE, WR_EPC, RD_EPC, JUMP} state_t;
  state_t      r_state;
  logic        r_eret;
  logic        r_done;
  logic [4:0]  r_code;
  logic [31:0] r_pc;
  logic [31:0] r_stat;
  logic [31:0] r_target;
  logic        w_take;
  // Status[0] is the global enable; bits 1..3 enable syscall/break/teq, other codes are never masked.
  assign w_take = cp0_rdata[0] && (r_code == 5'd8  ? cp0_rdata[1] :
                                   r_code == 5'd9  ? cp0_rdata[2] :
                                   r_code == 5'd13 ? cp0_rdata[3] : 1'b1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_eret   <= 1'b0;
      r_done   <= 1'b0;
      r_code   <= '0;
      r_pc     <= '0;
      r_stat   <= '0;
      r_target <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (exc_req) begin
            r_code  <= exc_code;
            r_pc    <= exc_pc;
            r_eret  <= 1'b0;
            r_state <= RD_STAT;
          end else if (eret_req) begin
            r_eret  <= 1'b1;
            r_state <= RD_STAT;
          end
        end
        RD_STAT: begin
          r_stat <= cp0_rdata;
          // a masked exception retires through IDLE with a done pulse and no CP0 side effects
          if (!r_eret && !w_take) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= WR_STAT;
          end
        end
        WR_STAT:  r_state <= r_eret ? RD_EPC : WR_CAUSE;
        WR_CAUSE: r_state <= WR_EPC;
        WR_EPC: begin
          r_target <= EXC_VECTOR;
          r_state  <= JUMP;
        end
        RD_EPC: begin
          r_target <= cp0_rdata;
          r_state  <= JUMP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_comb begin
    busy      = r_state != IDLE;
    cp0_r     = r_state == RD_STAT || r_state == RD_EPC;
    cp0_raddr = r_state == RD_STAT ? ADDR_STATUS : r_state == RD_EPC ? ADDR_EPC : 5'd0;
    cp0_w     = r_state == WR_STAT || r_state == WR_CAUSE || r_state == WR_EPC;
    cp0_waddr = r_state == WR_STAT ? ADDR_STATUS : r_state == WR_CAUSE ? ADDR_CAUSE :
                r_state == WR_EPC ? ADDR_EPC : 5'd0;
    cp0_wdata = r_state == WR_STAT ? (r_eret ? r_stat >> 5 : r_stat << 5) :
                r_state == WR_CAUSE ? {25'b0, r_code, 2'b00} :
                r_state == WR_EPC ? r_pc : 32'd0;
    pc_load   = r_state == JUMP;
    pc_target = r_state == JUMP ? r_target : 32'd0;
    done      = r_state == JUMP || r_done;
  end
endmodule

// File: tb/tb_cp0_exc_seq.sv
// tb_cp0_exc_seq: scoreboard bench for cp0_exc_seq against a CP0 register-file model.
module tb_cp0_exc_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] cp0_rdata;
  logic        cp0_r, cp0_w, busy, pc_load, done;
  logic [4:0]  cp0_raddr, cp0_waddr;
  logic [31:0] cp0_wdata, pc_target;

  cp0_exc_seq dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc),
    .eret_req(eret_req), .cp0_rdata(cp0_rdata), .cp0_r(cp0_r), .cp0_raddr(cp0_raddr),
    .cp0_w(cp0_w), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .busy(busy),
    .pc_load(pc_load), .pc_target(pc_target), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  always @(negedge clk)
    if (cp0_w) mem[cp0_waddr] <= cp0_wdata;
    else if (pre_en) mem[pre_a] <= pre_d;
  assign cp0_rdata = cp0_r ? mem[cp0_raddr] : 32'hDEAD_BEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected observable event: kind 0 = CP0 write, 1 = PC redirect, 2 = masked done
  typedef struct {
    int          t;
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } ev_t;
  ev_t q[$];
  logic [31:0] m [32];
  int total = 0;
  int bad = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic expect_ev(input string n, input int t, input logic [4:0] a, input logic [31:0] d);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s unexpected got_kind=%0d got_data=%h want=none", n, t, d);
    end else begin
      e = q.pop_front();
      check({n, "_kind"}, t, e.t);
      check({n, "_addr"}, 32'(a), 32'(e.a));
      check({n, "_data"}, d, e.d);
      check({n, "_cycle"}, cyc, e.c);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      check("bus", {29'b0, cp0_r & cp0_w, !cp0_r && cp0_raddr != 5'd0,
                    !cp0_w && (cp0_waddr != 5'd0 || cp0_wdata != 32'd0)}, 32'd0);
      if (cp0_w) expect_ev("cp0_write", 0, cp0_waddr, cp0_wdata);
      if (pc_load) begin
        check("jump_done", 32'(done), 32'd1);
        expect_ev("jump", 1, 5'd0, pc_target);
      end else if (done) expect_ev("masked_done", 2, 5'd0, 32'd0);
    end
  endtask

  task automatic preset(input logic [4:0] a, input logic [31:0] d);
    pre_a = a;
    pre_d = d;
    pre_en = 1'b1;
    @(negedge clk);
    #1 pre_en = 1'b0;
    m[a] = d;
  endtask

  // Drives one request cycle and records what CP0 and the PC should see, cycle by cycle.
  task automatic issue(input bit ex, input bit er, input logic [4:0] code, input logic [31:0] pc,
                       input bit epc_lands);
    int k;
    logic [31:0] s;
    bit en;
    k = cyc;
    s = m[12];
    exc_req = ex;
    eret_req = er;
    exc_code = code;
    exc_pc = pc;
    if (ex) begin
      en = s[0] && (code == 5'd8 ? s[1] : code == 5'd9 ? s[2] : code == 5'd13 ? s[3] : 1'b1);
      if (!en) q.push_back('{2, 5'd0, 32'd0, k + 2});
      else begin
        q.push_back('{0, 5'd12, s << 5, k + 2});
        q.push_back('{0, 5'd13, 32'(code) * 4, k + 3});
        q.push_back('{0, 5'd14, pc, k + 4});
        q.push_back('{1, 5'd0, 32'h0040_0004, k + 5});
        m[12] = s << 5;
        m[13] = 32'(code) * 4;
        if (epc_lands) m[14] = pc;
      end
    end else if (er) begin
      q.push_back('{0, 5'd12, s >> 5, k + 2});
      q.push_back('{1, 5'd0, m[14], k + 4});
      m[12] = s >> 5;
    end
    @(negedge clk);
    #1 exc_req = 1'b0;
    eret_req = 1'b0;
    exc_code = 5'($urandom);
    exc_pc = $urandom;
  endtask

  // Waits for IDLE; optionally throws a request at the busy sequencer at offset inj.
  task automatic wait_idle(input int inj);
    for (int i = 0; i < 20; i++) begin
      if (!busy) return;
      if (i == inj) begin
        exc_req = 1'b1;
        eret_req = 1'($urandom);
        exc_code = 5'd8;
      end
      @(negedge clk);
      #1 exc_req = 1'b0;
      eret_req = 1'b0;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_pc_load", 32'(pc_load), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cp0_r", 32'(cp0_r), 0);
    check("rst_cp0_w", 32'(cp0_w), 0);
    check("rst_raddr", 32'(cp0_raddr), 0);
    check("rst_waddr", 32'(cp0_waddr), 0);
    check("rst_wdata", cp0_wdata, 0);
    check("rst_target", pc_target, 0);
    rst = 1'b0;
    preset(12, 32'h0000_000F);
    preset(13, 32'h0);
    preset(14, 32'h0);
    issue(1, 0, 5'd8, 32'h0040_0100, 1);
    wait_idle(-1);
    check("syscall_status", mem[12], 32'h0000_01E0);
    check("syscall_cause", mem[13], 32'h0000_0020);
    check("syscall_epc", mem[14], 32'h0040_0100);
    issue(0, 1, 5'd0, 32'h0, 1);
    wait_idle(-1);
    check("eret_status", mem[12], 32'h0000_000F);
    preset(12, 32'h0000_0001);
    issue(1, 0, 5'd9, 32'h0040_0200, 1);
    wait_idle(-1);
    check("masked_status", mem[12], 32'h0000_0001);
    check("masked_epc", mem[14], 32'h0040_0100);
    preset(12, 32'h0000_000F);
    issue(1, 1, 5'd13, 32'h0040_0300, 1);
    wait_idle(2);
    check("both_epc", mem[14], 32'h0040_0300);
    preset(12, 32'h0000_000F);
    preset(14, 32'h1234_5678);
    issue(1, 0, 5'd8, 32'hCAFE_0000, 0);
    @(negedge clk);
    #1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_cp0_w", 32'(cp0_w), 0);
    check("abort_waddr", 32'(cp0_waddr), 0);
    check("abort_wdata", cp0_wdata, 0);
    check("abort_pc_load", 32'(pc_load), 0);
    check("abort_done", 32'(done), 0);
    q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort_idle", 32'(busy), 0);
    check("abort_epc_kept", mem[14], 32'h1234_5678);
    repeat (60) begin
      bit ex, er;
      logic [4:0] code;
      int inj;
      if ($urandom % 3 == 0) preset(12, $urandom);
      if ($urandom % 4 == 0) preset(14, $urandom);
      ex = ($urandom % 3) != 0;
      er = 1'($urandom);
      if (!ex && !er) er = 1'b1;
      case ($urandom % 4)
        0: code = 5'd8;
        1: code = 5'd9;
        2: code = 5'd13;
        default: code = 5'($urandom);
      endcase
      inj = ($urandom % 4 == 0) ? int'(1 + $urandom % 3) : -1;
      issue(ex, er, code, $urandom, 1);
      wait_idle(inj);
    end
    repeat (3) @(negedge clk);
    #1;
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
